// File: rtl/bg_pixel_shifter_pkg.sv
// Shared PPU background-pipeline constants, state encoding and the fine-X tap helper.
package bg_pixel_shifter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_ACTIVE   = 2'd2
    } bg_state_e;

    localparam int TILE_W          = 8;
    localparam int PREFETCH_CYCLES = 16;
    localparam int PIX_W           = 2;

    // Bit of the 16-bit shifter that holds the pixel currently on screen.
    function automatic logic [3:0] fine_tap(input logic [2:0] fx);
        return 4'd15 - {1'b0, fx};
    endfunction

endpackage

// File: rtl/bg_shift_pair.sv
// Bitplane shift register pair: two-tile window with byte load, pixel shift and fine-X tap.
module bg_shift_pair
    import bg_pixel_shifter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_pre,
    input  logic             shift,
    input  logic             load_low,
    input  logic [7:0]       pend0,
    input  logic [7:0]       pend1,
    input  logic [2:0]       fine_x,
    output logic [PIX_W-1:0] tap
);

    logic [15:0] sr0;
    logic [15:0] sr1;
    logic [3:0]  tap_idx;

    // Prefetch pushes whole bytes in; active shifts one pixel per clock and
    // refills the low byte on the last pixel of each tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr0 <= '0;
            sr1 <= '0;
        end else if (load_pre) begin
            sr0 <= {sr0[7:0], pend0};
            sr1 <= {sr1[7:0], pend1};
        end else if (shift) begin
            if (load_low) begin
                sr0 <= {sr0[14:7], pend0};
                sr1 <= {sr1[14:7], pend1};
            end else begin
                sr0 <= {sr0[14:0], 1'b0};
                sr1 <= {sr1[14:0], 1'b0};
            end
        end
    end

    assign tap_idx = fine_tap(fine_x);
    assign tap     = {sr1[tap_idx], sr0[tap_idx]};

endmodule

// File: rtl/bg_pixel_shifter.sv
// Background pixel shifter: fetches one scanline of tiles and emits 2-bit palette indices.
module bg_pixel_shifter
    import bg_pixel_shifter_pkg::*;
#(
    parameter int TILES_PER_LINE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_start,
    input  logic [7:0]       scanline,
    input  logic [2:0]       fine_x,
    output logic [4:0]       nt_col,
    input  logic [7:0]       nt_tile,
    output logic [7:0]       tile_num,
    output logic [2:0]       yoffset,
    input  logic [7:0]       line0,
    input  logic [7:0]       line1,
    output logic             pixel_valid,
    output logic [PIX_W-1:0] pixel
);

    localparam int ACTIVE_CYCLES = TILE_W * TILES_PER_LINE;
    localparam int CW            = $clog2(ACTIVE_CYCLES);
    localparam logic [CW-1:0] PREFETCH_LAST = CW'(PREFETCH_CYCLES - 1);
    localparam logic [CW-1:0] ACTIVE_LAST   = CW'(ACTIVE_CYCLES - 1);

    bg_state_e        state;
    logic [CW-1:0]    cyc;
    logic [2:0]       sub;
    logic [2:0]       row;
    logic [2:0]       fx;
    logic [4:0]       col;
    logic [7:0]       pend0;
    logic [7:0]       pend1;
    logic             load_pre;
    logic             shift;
    logic             load_low;
    logic [PIX_W-1:0] tap;

    assign sub = cyc[2:0];

    // Active periods fetch two columns ahead; 5-bit wrap makes the last two reuse columns 0 and 1.
    always_comb begin
        col = 5'd0;
        case (state)
            ST_PREFETCH: col = {4'd0, cyc[3]};
            ST_ACTIVE:   col = 5'(cyc >> 3) + 5'd2;
            default:     col = 5'd0;
        endcase
    end

    assign nt_col = col;

    assign load_pre = (state == ST_PREFETCH) && (sub == 3'd7) && !line_start;
    assign shift    = (state == ST_ACTIVE) && !line_start;
    assign load_low = shift && (sub == 3'd7);

    // Sequencer, fetch slots and output register; line_start always restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cyc         <= '0;
            row         <= '0;
            fx          <= '0;
            tile_num    <= '0;
            yoffset     <= '0;
            pend0       <= '0;
            pend1       <= '0;
            pixel_valid <= 1'b0;
            pixel       <= '0;
        end else if (line_start) begin
            state       <= ST_PREFETCH;
            cyc         <= '0;
            row         <= scanline[2:0];
            fx          <= fine_x;
            pixel_valid <= 1'b0;
            pixel       <= '0;
        end else begin
            pixel_valid <= (state == ST_ACTIVE);
            pixel       <= (state == ST_ACTIVE) ? tap : '0;
            if (state != ST_IDLE) begin
                if (sub == 3'd1) begin
                    tile_num <= nt_tile;
                    yoffset  <= row;
                end
                if (sub == 3'd3) begin
                    pend0 <= line0;
                    pend1 <= line1;
                end
            end
            case (state)
                ST_IDLE: begin
                    cyc <= '0;
                end
                ST_PREFETCH: begin
                    if (cyc == PREFETCH_LAST) begin
                        state <= ST_ACTIVE;
                        cyc   <= '0;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (cyc == ACTIVE_LAST) begin
                        state <= ST_IDLE;
                        cyc   <= '0;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cyc   <= '0;
                end
            endcase
        end
    end

    bg_shift_pair u_shift_pair (
        .clk      (clk),
        .rst      (rst),
        .load_pre (load_pre),
        .shift    (shift),
        .load_low (load_low),
        .pend0    (pend0),
        .pend1    (pend1),
        .fine_x   (fx),
        .tap      (tap)
    );

endmodule
